fp16_writeback_sequencer: RTL

//  Drains one accumulator row (LANES x FP32) from the MAC array into the writeback bus.

---
 rtl/fp_wb_pkg.sv | 22 ++
 rtl/fp32_to_fp16.sv | 94 +++++++++
 rtl/fp16_writeback_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fp_wb_pkg.sv
// Shared types for the FP16 writeback sequencer: IEEE flag bundle, FSM states, NaN helper.
package fp_wb_pkg;

    localparam int unsigned FLAG_W = 4;

    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    typedef enum logic {
        WB_IDLE,
        WB_RUN
    } wb_state_t;

    function automatic logic is_nan32(input logic [31:0] v);
        return (&v[30:23]) && (|v[22:0]);
    endfunction

endpackage

// File: rtl/fp32_to_fp16.sv
// FP32 -> FP16 converter, round-to-nearest-even; overflow saturates to max finite,
// Inf/NaN keep their class. mode=0 forwards the upper half of the input unchanged.
module fp32_to_fp16
    import fp_wb_pkg::*;
#(
    parameter int unsigned PARM_RM = 3
) (
    input  logic [31:0]        src,
    input  logic [PARM_RM-1:0] rm,
    input  logic               mode,
    input  fp_flags_t          flag_seed,
    output logic [15:0]        res,
    output fp_flags_t          flags
);

    logic        sign;
    logic [7:0]  exp8;
    logic [22:0] man;
    logic [4:0]  ebias;
    logic [7:0]  sub_sh;
    logic [35:0] sub_ext;
    logic [14:0] sum;
    logic        guard;
    logic        sticky;
    logic        rnd;
    fp_flags_t   f;
    logic        unused_rm;

    assign sign      = src[31];
    assign exp8      = src[30:23];
    assign man       = src[22:0];
    assign unused_rm = ^rm;
    assign flags     = f | flag_seed;

    always_comb begin
        res     = '0;
        f       = '0;
        ebias   = '0;
        sub_sh  = '0;
        sub_ext = '0;
        sum     = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        rnd     = 1'b0;
        if (!mode) begin
            res = src[31:16];
        end else if (exp8 == 8'hFF) begin
            if (man == '0) begin
                res = {sign, 5'h1F, 10'h000};
            end else begin
                res  = {sign, 5'h1F, 1'b1, man[21:13]};
                f.nv = ~man[22];
            end
        end else if (exp8 == 8'h00) begin
            res  = {sign, 15'h0000};
            f.uf = (man != '0);
            f.nx = (man != '0);
        end else if (exp8 >= 8'd143) begin
            res  = {sign, 15'h7BFF};
            f.of = 1'b1;
            f.nx = 1'b1;
        end else if (exp8 >= 8'd113) begin
            // exp - 112 taken modulo 32, since 112 = 3*32 + 16
            ebias  = exp8[4:0] - 5'd16;
            guard  = man[12];
            sticky = |man[11:0];
            rnd    = guard & (sticky | man[13]);
            sum    = {ebias, man[22:13]} + {14'h0000, rnd};
            if (sum[14:10] == 5'h1F) begin
                res  = {sign, 15'h7BFF};
                f.of = 1'b1;
                f.nx = 1'b1;
            end else begin
                res  = {sign, sum};
                f.nx = guard | sticky;
            end
        end else begin
            // Subnormal result; a carry out of the mantissa lands on the min normal
            sub_sh = 8'd112 - exp8;
            if (sub_sh > 8'd11) begin
                sub_sh = 8'd11;
            end
            sub_ext = {1'b1, man, 12'h000} >> sub_sh;
            guard   = sub_ext[25];
            sticky  = |sub_ext[24:0];
            rnd     = guard & (sticky | sub_ext[26]);
            sum     = {5'h00, sub_ext[35:26]} + {14'h0000, rnd};
            res     = {sign, sum};
            f.uf    = guard | sticky;
            f.nx    = guard | sticky;
        end
    end

endmodule

// File: rtl/fp16_writeback_sequencer.sv
// Drains one FP32 accumulator row into 32-bit writeback beats, either packing pairs of
// converted FP16 halves or passing FP32 lanes through, with row-sticky IEEE flags.
module fp16_writeback_sequencer
    import fp_wb_pkg::*;
#(
    parameter int unsigned LANES   = 8,
    parameter int unsigned CONV    = 2,
    parameter int unsigned PARM_RM = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_valid_i,
    output logic                  row_ready_o,
    input  logic [32*LANES-1:0]   row_data_i,
    input  logic                  row_mode_i,
    input  logic [PARM_RM-1:0]    row_rm_i,
    input  logic [FLAG_W-1:0]     row_flags_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_data_o,
    output logic                  out_last_o,
    output logic [FLAG_W-1:0]     out_flags_o
);

    localparam int unsigned     CW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0]   LAST_PACK = CW'(LANES / 2 - 1);
    localparam logic [CW-1:0]   LAST_PASS = CW'(LANES - 1);

    wb_state_t                  state;
    logic [LANES-1:0][31:0]     row_q;
    logic                       mode_q;
    logic [PARM_RM-1:0]         rm_q;
    logic [FLAG_W-1:0]          sticky_q;
    logic [CW-1:0]              cnt_q;

    logic [CW-1:0]              pair_base;
    logic [31:0]                conv_src   [CONV];
    logic [15:0]                half       [CONV];
    fp_flags_t                  conv_flags [CONV];
    logic [31:0]                beat_data;
    logic [FLAG_W-1:0]          beat_flags;
    logic                       beat_last;
    logic [FLAG_W-1:0]          sticky_nxt;
    logic                       load;

    assign pair_base = cnt_q << 1;

    always_comb begin
        for (int c = 0; c < CONV; c++) begin
            conv_src[c] = row_q[pair_base | CW'(c)];
        end
    end

    for (genvar g = 0; g < CONV; g++) begin : g_conv
        fp32_to_fp16 #(
            .PARM_RM (PARM_RM)
        ) u_conv (
            .src       (conv_src[g]),
            .rm        (rm_q),
            .mode      (1'b1),
            .flag_seed ('0),
            .res       (half[g]),
            .flags     (conv_flags[g])
        );
    end

    always_comb begin
        beat_flags = '0;
        if (mode_q) begin
            beat_data = {half[1], half[0]};
            for (int c = 0; c < CONV; c++) begin
                beat_flags = beat_flags | conv_flags[c];
            end
            beat_last = (cnt_q == LAST_PACK);
        end else begin
            beat_data     = row_q[cnt_q];
            beat_flags[3] = is_nan32(row_q[cnt_q]);
            beat_last     = (cnt_q == LAST_PASS);
        end
    end

    assign sticky_nxt = sticky_q | beat_flags;
    // Once the last beat is loaded nothing more loads until it is accepted
    assign load = (state == WB_RUN) && (!out_valid_o || (out_ready_i && !out_last_o));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WB_IDLE;
            row_q       <= '0;
            mode_q      <= 1'b0;
            rm_q        <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
            row_ready_o <= 1'b1;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_flags_o <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (row_valid_i) begin
                        row_q       <= row_data_i;
                        mode_q      <= row_mode_i;
                        rm_q        <= row_rm_i;
                        sticky_q    <= row_flags_i;
                        cnt_q       <= '0;
                        row_ready_o <= 1'b0;
                        state       <= WB_RUN;
                    end
                end
                WB_RUN: begin
                    if (out_valid_o && out_ready_i && out_last_o) begin
                        out_valid_o <= 1'b0;
                        out_data_o  <= '0;
                        out_last_o  <= 1'b0;
                        out_flags_o <= '0;
                        row_ready_o <= 1'b1;
                        state       <= WB_IDLE;
                    end else if (load) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= beat_data;
                        out_last_o  <= beat_last;
                        out_flags_o <= beat_last ? sticky_nxt : '0;
                        sticky_q    <= sticky_nxt;
                        cnt_q       <= cnt_q + CW'(1);
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule
